// File: rtl/renkon_conv_wfetch_pkg.sv
// rtl/renkon_conv_wfetch_pkg.sv - shared widths, filter size and FSM encoding for the weight fetcher
package renkon_conv_wfetch_pkg;

  // Signed weight word width
  localparam int WF_DWIDTH  = 16;
  // Weight-memory address width
  localparam int WF_WAWIDTH = 12;
  // Filter edge; a filter holds WF_FSIZE*WF_FSIZE weights
  localparam int WF_FSIZE   = 5;

  // Fetch controller states
  typedef enum logic [1:0] {
    WF_IDLE  = 2'd0,
    WF_FETCH = 2'd1,
    WF_DRAIN = 2'd2,
    WF_DONE  = 2'd3
  } wf_state_e;

endpackage

// File: rtl/renkon_conv_wfetch.sv
// rtl/renkon_conv_wfetch.sv - streams one filter of weights from memory into the downstream shift register (optional bias word: WFETCH_BIAS_EN)
module renkon_conv_wfetch
  import renkon_conv_wfetch_pkg::*;
#(
  parameter int DWIDTH  = WF_DWIDTH,
  parameter int WAWIDTH = WF_WAWIDTH,
  parameter int FSIZE   = WF_FSIZE
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      start,
  input  logic [WAWIDTH-1:0]        base_addr,
  output logic [WAWIDTH-1:0]        mem_addr,
  output logic                      mem_re,
  input  logic signed [DWIDTH-1:0]  mem_rdata,
  output logic signed [DWIDTH-1:0]  read_weight,
  output logic                      wreg_we,
  output logic                      busy,
  output logic                      done
`ifdef WFETCH_BIAS_EN
  ,
  output logic signed [DWIDTH-1:0]  bias
`endif
);

  localparam int NWEIGHT = FSIZE * FSIZE;
`ifdef WFETCH_BIAS_EN
  // The bias word follows the filter weights in memory
  localparam int NREAD   = NWEIGHT + 1;
`else
  localparam int NREAD   = NWEIGHT;
`endif
  localparam int CWIDTH  = $clog2(NREAD + 1);
  localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(NREAD - 1);
`ifdef WFETCH_BIAS_EN
  localparam logic [CWIDTH-1:0] BIAS_IDX = CWIDTH'(NWEIGHT);
`endif

  wf_state_e                r_state;
  wf_state_e                w_state_nxt;
  logic [WAWIDTH-1:0]       r_mem_addr;
  logic                     r_mem_re;
  logic [CWIDTH-1:0]        r_cnt;
  logic                     r_v1;
  logic                     r_v2;
  logic                     r_wreg_we;
  logic signed [DWIDTH-1:0] r_read_weight;
  logic                     w_accept;
  logic                     w_last_addr;
  logic                     w_shift;
  logic                     w_busy;
  logic                     w_done;
`ifdef WFETCH_BIAS_EN
  logic                     r_tag1;
  logic signed [DWIDTH-1:0] r_bias;
`endif

  assign w_accept    = (r_state == WF_IDLE) && start;
  assign w_last_addr = (r_cnt == LAST_IDX);

`ifdef WFETCH_BIAS_EN
  // Only filter weights go to the shift register; the tagged bias word is diverted
  assign w_shift = r_v1 && !r_tag1;
`else
  assign w_shift = r_v1;
`endif

  // State register
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= WF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DRAIN ends once the read pipeline has emptied its final word
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WF_IDLE:  if (start)          w_state_nxt = WF_FETCH;
      WF_FETCH: if (w_last_addr)    w_state_nxt = WF_DRAIN;
      WF_DRAIN: if (r_v2 && !r_v1)  w_state_nxt = WF_DONE;
      WF_DONE:                      w_state_nxt = WF_IDLE;
      default:                      w_state_nxt = WF_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      WF_IDLE:  w_busy = 1'b0;
      WF_FETCH: w_busy = 1'b1;
      WF_DRAIN: w_busy = 1'b1;
      WF_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default:  w_busy = 1'b0;
    endcase
  end

  // Address counter: first address is loaded with the accepted start, then steps once per FETCH cycle
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_mem_addr <= '0;
      r_mem_re   <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_mem_addr <= base_addr;
      r_mem_re   <= 1'b1;
      r_cnt      <= '0;
    end else if (r_state == WF_FETCH) begin
      if (w_last_addr) begin
        r_mem_re <= 1'b0;
      end else begin
        r_mem_addr <= r_mem_addr + WAWIDTH'(1);
        r_cnt      <= r_cnt + CWIDTH'(1);
      end
    end
  end

  // Two-stage valid pipeline: stage 1 marks memory data present, stage 2 marks the registered word
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_wreg_we <= 1'b0;
    end else begin
      r_v1      <= r_mem_re;
      r_v2      <= r_v1;
      r_wreg_we <= w_shift;
    end
  end

  // Weight word register; holds its value whenever no shift is in progress
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_read_weight <= '0;
    end else if (w_shift) begin
      r_read_weight <= mem_rdata;
    end
  end

`ifdef WFETCH_BIAS_EN
  // Tag the read that fetches the bias word and capture it when its data returns
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_tag1 <= 1'b0;
      r_bias <= '0;
    end else begin
      r_tag1 <= r_mem_re && (r_cnt == BIAS_IDX);
      if (r_v1 && r_tag1) begin
        r_bias <= mem_rdata;
      end
    end
  end

  assign bias = r_bias;
`endif

  assign mem_addr    = r_mem_addr;
  assign mem_re      = r_mem_re;
  assign read_weight = r_read_weight;
  assign wreg_we     = r_wreg_we;
  assign busy        = w_busy;
  assign done        = w_done;

endmodule

// File: tb/tb_renkon_conv_wfetch.sv
// tb/tb_renkon_conv_wfetch.sv - directed self-checking bench for renkon_conv_wfetch
module tb_renkon_conv_wfetch;

`ifdef WFETCH_BIAS_EN
  localparam int EXP_DONE  = 29;
  localparam int EXP_NREAD = 26;
`else
  localparam int EXP_DONE  = 28;
  localparam int EXP_NREAD = 25;
`endif

  logic               clk;
  logic               xrst;
  logic               start;
  logic [11:0]        base_addr;
  logic [11:0]        mem_addr;
  logic               mem_re;
  logic signed [15:0] mem_rdata;
  logic signed [15:0] read_weight;
  logic               wreg_we;
  logic               busy;
  logic               done;
`ifdef WFETCH_BIAS_EN
  logic signed [15:0] bias;
  logic signed [15:0] bias_t28;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;
  int mode  = 0;

  int                 re_t[$];
  logic [11:0]        re_a[$];
  int                 we_t[$];
  logic signed [15:0] we_d[$];
  int                 done_t[$];
  int                 busy_first;
  int                 busy_last;
  bit                 busy_seen;

  renkon_conv_wfetch dut (
    .clk         (clk),
    .xrst        (xrst),
    .start       (start),
    .base_addr   (base_addr),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .read_weight (read_weight),
    .wreg_we     (wreg_we),
    .busy        (busy),
    .done        (done)
`ifdef WFETCH_BIAS_EN
    ,
    .bias        (bias)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [15:0] word_of(input logic [11:0] a);
    if (mode == 0) return 16'(a) + 16'sd100;
    return -$signed({4'b0, a});
  endfunction

  // Memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= word_of(mem_addr);
  end

  // Event recorder, sampled away from the active edge
  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (mem_re) begin re_t.push_back(rel); re_a.push_back(mem_addr); end
    if (wreg_we) begin we_t.push_back(rel); we_d.push_back(read_weight); end
    if (done) done_t.push_back(rel);
    if (busy) begin
      if (!busy_seen) busy_first = rel;
      busy_seen = 1'b1;
      busy_last = rel;
    end
`ifdef WFETCH_BIAS_EN
    if (rel == 28) bias_t28 = bias;
`endif
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start at T0 with base b; optional extra start pulses at x1/x2 and reset assertion at xr
  task automatic run(input logic [11:0] b, input int x1, input int x2, input int xr, input int ncyc);
    @(posedge clk); #1;
    base_addr = b;
    start     = 1'b1;
    t0        = cyc;
    re_t.delete(); re_a.delete(); we_t.delete(); we_d.delete(); done_t.delete();
    busy_seen = 1'b0; busy_first = -1; busy_last = -1;
    for (int r = 1; r <= ncyc; r++) begin
      @(posedge clk); #1;
      start = (r == x1) || (r == x2);
      if (r == xr) begin
        xrst = 1'b0;
        #1;
        chk("rst_async_wreg_we", wreg_we, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_mem_re", mem_re, 0);
      end
      if (xr > 0 && r == xr + 2) xrst = 1'b1;
    end
    start = 1'b0;
  endtask

  function automatic longint qi(input int idx, input bit dq);
    if (dq) return (we_d.size() > idx) ? longint'(we_d[idx]) : -99999;
    return (re_a.size() > idx) ? longint'(re_a[idx]) : -99999;
  endfunction

  initial begin
    logic signed [15:0] sr[25];
    int gaps;
    int late;

    xrst = 1'b0; start = 1'b0; base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_re", mem_re, 0);
    chk("reset_read_weight", read_weight, 0);
    chk("reset_wreg_we", wreg_we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    xrst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic load, base 40, word[a]=a+100
    mode = 0;
    run(12'd40, -1, -1, -1, 40);
    chk("b40_nread", re_t.size(), EXP_NREAD);
    chk("b40_first_re_t", (re_t.size() > 0) ? re_t[0] : -1, 1);
    chk("b40_addr0", qi(0, 0), 40);
    chk("b40_addr24", qi(24, 0), 64);
    chk("b40_nwe", we_t.size(), 25);
    chk("b40_we_first", (we_t.size() > 0) ? we_t[0] : -1, 3);
    chk("b40_we_last", (we_t.size() > 24) ? we_t[24] : -1, 27);
    gaps = 0;
    for (int i = 1; i < we_t.size(); i++) if (we_t[i] != we_t[i-1] + 1) gaps++;
    chk("b40_we_contig", gaps, 0);
    for (int i = 0; i < 25; i++) sr[i] = '0;
    foreach (we_d[j]) begin
      for (int i = 0; i < 24; i++) sr[i] = sr[i+1];
      sr[24] = we_d[j];
    end
    chk("b40_weight0", sr[0], 140);
    chk("b40_weight12", sr[12], 152);
    chk("b40_weight24", sr[24], 164);
    chk("b40_ndone", done_t.size(), 1);
    chk("b40_done_t", (done_t.size() > 0) ? done_t[0] : -1, EXP_DONE);
    chk("b40_busy_first", busy_first, 1);
    chk("b40_busy_last", busy_last, EXP_DONE);
    chk("b40_hold", read_weight, 164);

    // Address wrap at the top of the 12-bit space
    run(12'd4090, -1, -1, -1, 40);
    chk("wrap_addr5", qi(5, 0), 4095);
    chk("wrap_addr6", qi(6, 0), 0);
    chk("wrap_addr24", qi(24, 0), 18);
    chk("wrap_data0", qi(0, 1), 4190);
    chk("wrap_data5", qi(5, 1), 4195);
    chk("wrap_data6", qi(6, 1), 100);
    chk("wrap_data24", qi(24, 1), 118);

    // Starts while busy (FETCH and DONE cycle) are ignored
    run(12'd200, 5, EXP_DONE, -1, 45);
    chk("ign_nwe", we_t.size(), 25);
    chk("ign_ndone", done_t.size(), 1);
    chk("ign_nread", re_t.size(), EXP_NREAD);

    // Reset asserted at T10 abandons the load
    run(12'd300, -1, -1, 10, 40);
    chk("rst_nread", re_t.size(), 9);
    chk("rst_nwe", we_t.size(), 7);
    chk("rst_ndone", done_t.size(), 0);
    late = 0;
    foreach (re_t[i]) if (re_t[i] >= 10) late++;
    foreach (we_t[i]) if (we_t[i] >= 10) late++;
    chk("rst_no_activity", late, 0);
    chk("rst_read_weight", read_weight, 0);

    // Back-to-back loads
    run(12'd0, EXP_DONE + 1, -1, -1, 70);
    chk("b2b_nwe", we_t.size(), 50);
    chk("b2b_ndone", done_t.size(), 2);
    chk("b2b_done0", (done_t.size() > 0) ? done_t[0] : -1, EXP_DONE);
    chk("b2b_done1", (done_t.size() > 1) ? done_t[1] : -1, 2 * EXP_DONE + 1);
    chk("b2b_we_second", (we_t.size() > 25) ? we_t[25] : -1, EXP_DONE + 4);

`ifdef WFETCH_BIAS_EN
    // Bias word: base 0, word[a]=-a
    mode = 1;
    run(12'd0, -1, -1, -1, 40);
    chk("bias_nwe", we_t.size(), 25);
    chk("bias_data0", qi(0, 1), 0);
    chk("bias_data24", qi(24, 1), -24);
    chk("bias_we_last", (we_t.size() > 24) ? we_t[24] : -1, 27);
    chk("bias_val_t28", bias_t28, -25);
    chk("bias_done_t", (done_t.size() > 0) ? done_t[0] : -1, 29);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
